// File: rtl/alimentador_pkg.sv
// Shared definitions for the instruction feeder: FSM state encoding,
// the mvi opcode, the halt word and small helpers used by the FSM.
package alimentador_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    LE_MEM   = 3'd1,
    ENVIA    = 3'd2,
    IMEDIATO = 3'd3,
    ESPERA   = 3'd4,
    FIM      = 3'd5,
    ERRO     = 3'd6
  } estado_t;

  localparam logic [2:0]  OPC_MVI     = 3'b001;
  localparam logic [15:0] PALAVRA_FIM = 16'hFFFF;

  // mvi is recognised by the opcode field of the first instruction word.
  function automatic logic eh_mvi(input logic [15:0] palavra);
    return palavra[8:6] == OPC_MVI;
  endfunction

  function automatic logic [7:0] incrementa_sat(input logic [7:0] valor);
    return (valor == 8'hFF) ? valor : valor + 8'd1;
  endfunction

endpackage

// File: rtl/alimentador_instrucoes_contador_espera.sv
// Watchdog for the ESPERA state: counts enabled cycles since the last Clear
// and flags the cycle in which the count would reach TIMEOUT.
module contador_espera #(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Clear,
  input  logic Habilita,
  output logic Estourou
);

  localparam int LARG_CONT = $clog2(TIMEOUT + 1);

  logic [LARG_CONT-1:0] conta_q, conta_d;

  always_comb begin
    // NOTE: the default assignment comes first so every path assigns conta_d and no latch is inferred.
    conta_d = conta_q;
    if (Clear) begin
      conta_d = '0;
    end else if (Habilita && (conta_q != LARG_CONT'(TIMEOUT))) begin
      conta_d = conta_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
    conta_q <= conta_d;
  end

  // Asserted in the enabled cycle whose edge would bring the count to TIMEOUT.
  assign Estourou = Habilita && (conta_q == LARG_CONT'(TIMEOUT - 1));

endmodule

// File: rtl/alimentador_instrucoes.sv
// Instruction feeder: fetches words from a registered-read ROM, strobes Run
// per instruction, supplies the mvi immediate and waits on Done with a watchdog.
module alimentador_instrucoes
  import alimentador_pkg::*;
#(
  parameter int LARG_END = 5,
  parameter int TIMEOUT  = 15
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Iniciar,
  output logic [LARG_END-1:0] MemEndereco,
  input  logic [15:0]         MemDado,
  input  logic                Done,
  output logic [15:0]         DIN,
  output logic                Run,
  output logic                Ocupado,
  output logic                Fim,
  output logic                Erro,
  output logic [7:0]          NumInstr
);

  estado_t             estado_q, estado_d;
  logic [LARG_END-1:0] pc_q, pc_d;
  logic [15:0]         din_q, din_d;
  logic [7:0]          num_q, num_d;

  logic palavra_fim;
  logic mvi_truncado;
  logic emite;
  logic entra_espera;
  logic limpa_cont;
  logic habilita_cont;
  logic estourou;

  assign palavra_fim  = (MemDado == PALAVRA_FIM);
  // An mvi in the last slot would need its immediate from a wrapped address.
  assign mvi_truncado = eh_mvi(MemDado) && (&pc_q);
  assign emite        = (estado_q == ENVIA) && !palavra_fim && !mvi_truncado;

  assign habilita_cont = (estado_q == ESPERA);
  assign limpa_cont    = entra_espera || !Resetn;

  contador_espera #(
    .TIMEOUT (TIMEOUT)
  ) u_contador_espera (
    .Clock    (Clock),
    .Clear    (limpa_cont),
    .Habilita (habilita_cont),
    .Estourou (estourou)
  );

  // State register and datapath registers.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      estado_q <= OCIOSO;
      pc_q     <= '0;
      din_q    <= '0;
      num_q    <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      din_q    <= din_d;
      num_q    <= num_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    estado_d     = estado_q;
    pc_d         = pc_q;
    din_d        = din_q;
    num_d        = num_q;
    entra_espera = 1'b0;
    case (estado_q)
      OCIOSO, FIM, ERRO: begin
        if (Iniciar) begin
          estado_d = LE_MEM;
          pc_d     = '0;
          num_d    = '0;
        end
      end
      LE_MEM: estado_d = ENVIA;
      ENVIA: begin
        if (palavra_fim) begin
          estado_d = FIM;
        end else if (mvi_truncado) begin
          estado_d = ERRO;
        end else begin
          din_d = MemDado;
          pc_d  = pc_q + 1'b1;
          if (eh_mvi(MemDado)) begin
            estado_d = IMEDIATO;
          end else begin
            estado_d     = ESPERA;
            entra_espera = 1'b1;
          end
        end
      end
      IMEDIATO: begin
        din_d = MemDado;
        pc_d  = pc_q + 1'b1;
        if (Done) begin
          num_d    = incrementa_sat(num_q);
          estado_d = (pc_d == '0) ? FIM : LE_MEM;
        end else begin
          estado_d     = ESPERA;
          entra_espera = 1'b1;
        end
      end
      ESPERA: begin
        // Done in the same cycle as the watchdog expiry takes priority.
        if (Done) begin
          num_d    = incrementa_sat(num_q);
          estado_d = (pc_q == '0) ? FIM : LE_MEM;
        end else if (estourou) begin
          estado_d = ERRO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    Run     = emite;
    DIN     = din_q;
    if (emite || (estado_q == IMEDIATO)) begin
      DIN = MemDado;
    end
    Ocupado = (estado_q == LE_MEM) || (estado_q == ENVIA) ||
              (estado_q == IMEDIATO) || (estado_q == ESPERA);
    Fim     = (estado_q == FIM);
    Erro    = (estado_q == ERRO);
  end

  // The ROM registers its address, so it is given the next pc: the mvi
  // immediate is then already on MemDado during IMEDIATO.
  assign MemEndereco = pc_d;
  assign NumInstr    = num_q;

endmodule

// File: tb/tb_alimentador_instrucoes.sv
// Self-checking bench: a program-walking model precomputes per-cycle stimulus
// and expected outputs; one loop drives inputs and compares every cycle.
module tb_alimentador_instrucoes;

  localparam int LARG_END = 5;
  localparam int TIMEOUT  = 15;
  localparam int NPAL     = 32;
  localparam int NC       = 16384;
  localparam int NEP      = 40;

  logic          clk = 1'b0;
  logic          Resetn;
  logic          Iniciar;
  logic          Done;
  logic [4:0]    MemEndereco;
  logic [15:0]   MemDado = '0;
  logic [15:0]   DIN;
  logic          Run;
  logic          Ocupado;
  logic          Fim;
  logic          Erro;
  logic [7:0]    NumInstr;

  alimentador_instrucoes #(
    .LARG_END (LARG_END),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .Clock       (clk),
    .Resetn      (Resetn),
    .Iniciar     (Iniciar),
    .MemEndereco (MemEndereco),
    .MemDado     (MemDado),
    .Done        (Done),
    .DIN         (DIN),
    .Run         (Run),
    .Ocupado     (Ocupado),
    .Fim         (Fim),
    .Erro        (Erro),
    .NumInstr    (NumInstr)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM: data valid one cycle after the address.
  logic [15:0] rom [NPAL];
  always @(posedge clk) MemDado <= rom[MemEndereco];

  // Per-cycle stimulus and expectations.
  bit          t_ini  [NC];
  bit          t_done [NC];
  bit          t_rstn [NC];
  bit          e_val  [NC];
  bit          e_run  [NC];
  bit          e_ocup [NC];
  bit          e_fim  [NC];
  bit          e_erro [NC];
  logic [15:0] e_din  [NC];
  logic [7:0]  e_num  [NC];

  logic [15:0] rom_ep [NEP][NPAL];
  int          ep_cyc [NEP];
  int          ep_end [NEP];
  int          n_ep;
  int          rst_cyc;
  int          n_cyc;

  // Model state while walking the programs.
  int          c;
  logic [15:0] m_din;
  int          m_n;
  bit          m_fim;
  bit          m_erro;
  int          ini_pct;

  int          n_chk;
  int          n_pass;
  int          cur_k;

  function automatic bit is_mvi(input logic [15:0] w);
    return w[8:6] == 3'b001;
  endfunction

  function automatic int pick_delay(input int mode);
    int r;
    if (mode >= 0) return mode;
    r = $urandom_range(19);
    if (r == 0) return TIMEOUT + 1;
    if (r == 1) return TIMEOUT;
    return $urandom_range(4);
  endfunction

  task automatic emit(input bit run, input logic [15:0] din, input bit ocup);
    e_val[c]  = 1'b1;
    e_run[c]  = run;
    e_din[c]  = din;
    e_ocup[c] = ocup;
    e_fim[c]  = m_fim;
    e_erro[c] = m_erro;
    e_num[c]  = 8'(m_n);
    t_rstn[c] = 1'b1;
  endtask

  task automatic busy_noise(input bit done_too);
    if ($urandom_range(99) < ini_pct) t_ini[c] = 1'b1;
    if (done_too && ($urandom_range(3) == 0)) t_done[c] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      emit(1'b0, m_din, 1'b0);
      if ($urandom_range(3) == 0) t_done[c] = 1'b1;
      c++;
    end
  endtask

  task automatic count_instr();
    m_n = (m_n >= 255) ? 255 : m_n + 1;
  endtask

  // Walks one program run from its Iniciar cycle to its end state.
  task automatic run_episode(input int e, input int mode, input bit do_rst);
    int          pc;
    int          d;
    logic [15:0] w;
    bit          done_seen;
    emit(1'b0, m_din, 1'b0);
    t_ini[c]  = 1'b1;
    ep_cyc[e] = c;
    c++;
    m_fim  = 1'b0;
    m_erro = 1'b0;
    m_n    = 0;
    pc     = 0;
    forever begin
      emit(1'b0, m_din, 1'b1); busy_noise(1'b1); c++;
      w = rom_ep[e][pc];
      if (w == 16'hFFFF) begin
        emit(1'b0, m_din, 1'b1); busy_noise(1'b1); c++;
        m_fim = 1'b1;
        break;
      end
      if (is_mvi(w) && (pc == NPAL - 1)) begin
        emit(1'b0, m_din, 1'b1); busy_noise(1'b1); c++;
        m_erro = 1'b1;
        break;
      end
      emit(1'b1, w, 1'b1); busy_noise(1'b1); c++;
      m_din = w;
      pc    = (pc + 1) % NPAL;
      d     = pick_delay(mode);
      if (is_mvi(w)) begin
        m_din = rom_ep[e][pc];
        pc    = (pc + 1) % NPAL;
        emit(1'b0, m_din, 1'b1); busy_noise(1'b0);
        if (d == 0) begin
          t_done[c] = 1'b1;
          c++;
          count_instr();
          if (pc == 0) begin
            m_fim = 1'b1;
            break;
          end
          continue;
        end
        c++;
      end else if (d == 0) begin
        d = 1;
      end
      done_seen = 1'b0;
      for (int j = 1; j <= TIMEOUT; j++) begin
        emit(1'b0, m_din, 1'b1);
        if (do_rst && (j == 2)) begin
          t_rstn[c] = 1'b0;
          rst_cyc   = c;
          c++;
          m_din  = '0;
          m_n    = 0;
          m_fim  = 1'b0;
          m_erro = 1'b0;
          ep_end[e] = c;
          return;
        end
        busy_noise(1'b0);
        if (j == d) begin
          t_done[c] = 1'b1;
          done_seen = 1'b1;
          c++;
          break;
        end
        c++;
      end
      if (!done_seen) begin
        m_erro = 1'b1;
        break;
      end
      count_instr();
      if (pc == 0) begin
        m_fim = 1'b1;
        break;
      end
    end
    ep_end[e] = c;
  endtask

  task automatic clear_rom(input int e);
    for (int i = 0; i < NPAL; i++) rom_ep[e][i] = 16'h0000;
  endtask

  task automatic make_random_rom(input int e, input int halt_pct);
    logic [15:0] w;
    for (int i = 0; i < NPAL; i++) begin
      w = 16'($urandom);
      if ($urandom_range(99) < halt_pct) begin
        w = 16'hFFFF;
      end else if ($urandom_range(99) < 30) begin
        w[8:6] = 3'b001;
      end else begin
        if (w[8:6] == 3'b001) w[8:6] = 3'b010;
        if (w == 16'hFFFF) w = 16'h0000;
      end
      rom_ep[e][i] = w;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cur_k, act, exp);
  endtask

  initial begin
    int ep_ptr;
    n_chk   = 0;
    n_pass  = 0;
    c       = 0;
    m_din   = '0;
    m_n     = 0;
    m_fim   = 1'b0;
    m_erro  = 1'b0;
    ini_pct = 0;
    rst_cyc = -1;
    for (int i = 0; i < NPAL; i++) rom[i] = 16'h0000;

    // Power-up reset for cycles 0..2; outputs are checked from cycle 1.
    t_rstn[0] = 1'b0;
    c = 1;
    repeat (2) begin
      emit(1'b0, 16'h0000, 1'b0);
      t_rstn[c] = 1'b0;
      c++;
    end
    idle(2);

    // 0: plain mv then halt, Done two cycles after Run.
    clear_rom(0); rom_ep[0][0] = 16'h0008; rom_ep[0][1] = 16'hFFFF;
    run_episode(0, 2, 1'b0); idle(3);
    // 1: mvi with immediate, Done in the cycle after Run.
    clear_rom(1); rom_ep[1][0] = 16'h0040; rom_ep[1][1] = 16'h00A5; rom_ep[1][2] = 16'hFFFF;
    run_episode(1, 0, 1'b0); idle(3);
    // 2: processor never answers.
    clear_rom(2); rom_ep[2][0] = 16'h0008; rom_ep[2][1] = 16'hFFFF;
    run_episode(2, TIMEOUT + 1, 1'b0); idle(3);
    // 3: mvi in the last address slot.
    for (int i = 0; i < NPAL - 1; i++) rom_ep[3][i] = 16'h0008 + 16'(i << 9);
    rom_ep[3][NPAL-1] = 16'h0040;
    run_episode(3, 1, 1'b0); idle(3);
    // 4: reset while waiting for Done, 5: restart from address 0.
    clear_rom(4); rom_ep[4][0] = 16'h0008; rom_ep[4][1] = 16'h0010; rom_ep[4][2] = 16'hFFFF;
    run_episode(4, 5, 1'b1); idle(3);
    clear_rom(5); rom_ep[5][0] = 16'h0008; rom_ep[5][1] = 16'hFFFF;
    run_episode(5, 2, 1'b0); idle(3);
    // 6: Done arrives in the cycle the watchdog expires.
    clear_rom(6); rom_ep[6][0] = 16'h0008; rom_ep[6][1] = 16'hFFFF;
    run_episode(6, TIMEOUT, 1'b0); idle(3);
    // 7: full address space without halt, Iniciar hammered while busy.
    for (int i = 0; i < NPAL; i++) rom_ep[7][i] = 16'h1000 + 16'(i);
    ini_pct = 50;
    run_episode(7, 1, 1'b0); idle(3);

    ini_pct = 12;
    n_ep = 8;
    for (int e = 8; e < NEP; e++) begin
      if (c > NC - 1500) break;
      make_random_rom(e, (e % 4 == 0) ? 0 : 6);
      run_episode(e, -1, (e % 7 == 0));
      idle($urandom_range(1, 4));
      n_ep = e + 1;
    end
    idle(4);
    n_cyc = c;

    Resetn  = 1'b0;
    Iniciar = 1'b0;
    Done    = 1'b0;
    ep_ptr  = 0;
    for (int k = 1; k < n_cyc; k++) begin
      @(negedge clk);
      cur_k = k;
      if (e_val[k]) begin
        check("run",      32'(Run),      32'(e_run[k]));
        check("din",      32'(DIN),      32'(e_din[k]));
        check("ocupado",  32'(Ocupado),  32'(e_ocup[k]));
        check("fim",      32'(Fim),      32'(e_fim[k]));
        check("erro",     32'(Erro),     32'(e_erro[k]));
        check("numinstr", 32'(NumInstr), 32'(e_num[k]));
      end
      if (k == 1) check("reset_addr", 32'(MemEndereco), 32'h0);
      if (k == ep_cyc[0] + 2) begin
        check("mv_run", 32'(Run), 32'h1);
        check("mv_din", 32'(DIN), 32'h0008);
      end
      if (k == ep_cyc[0] + 3) check("mv_run_once", 32'(Run), 32'h0);
      if (k == ep_cyc[0] + 7) begin
        check("mv_num",  32'(NumInstr), 32'h1);
        check("mv_fim",  32'(Fim),      32'h1);
        check("mv_ocup", 32'(Ocupado),  32'h0);
      end
      if (k == ep_cyc[1] + 2) begin
        check("mvi_run", 32'(Run), 32'h1);
        check("mvi_din", 32'(DIN), 32'h0040);
      end
      if (k == ep_cyc[1] + 3) begin
        check("mvi_imm",     32'(DIN), 32'h00A5);
        check("mvi_imm_run", 32'(Run), 32'h0);
      end
      if (k == ep_cyc[1] + 6) begin
        check("mvi_num", 32'(NumInstr), 32'h1);
        check("mvi_fim", 32'(Fim),      32'h1);
      end
      if (k == ep_cyc[2] + 2 + TIMEOUT) check("wd_not_yet", 32'(Erro), 32'h0);
      if (k == ep_cyc[2] + 3 + TIMEOUT) begin
        check("wd_erro", 32'(Erro), 32'h1);
        check("wd_run",  32'(Run),  32'h0);
      end
      if (k == ep_end[3]) begin
        check("mvi31_num",  32'(NumInstr), 32'd31);
        check("mvi31_erro", 32'(Erro),     32'h1);
      end
      if (k == rst_cyc + 1) begin
        check("rst_din",  32'(DIN),         32'h0);
        check("rst_run",  32'(Run),         32'h0);
        check("rst_addr", 32'(MemEndereco), 32'h0);
        check("rst_ocup", 32'(Ocupado),     32'h0);
        check("rst_num",  32'(NumInstr),    32'h0);
      end
      if (k == ep_cyc[5] + 7) begin
        check("restart_num", 32'(NumInstr), 32'h1);
        check("restart_fim", 32'(Fim),      32'h1);
      end
      if (k == ep_end[6]) begin
        check("late_done_fim",  32'(Fim),  32'h1);
        check("late_done_erro", 32'(Erro), 32'h0);
      end
      if (k == ep_end[7]) begin
        check("wrap_num", 32'(NumInstr), 32'd32);
        check("wrap_fim", 32'(Fim),      32'h1);
      end
      if ((ep_ptr < n_ep) && (k == ep_cyc[ep_ptr])) begin
        for (int i = 0; i < NPAL; i++) rom[i] = rom_ep[ep_ptr][i];
        ep_ptr++;
      end
      Resetn  = t_rstn[k];
      Iniciar = t_ini[k];
      Done    = t_done[k];
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alimentador_instrucoes.md
# alimentador_instrucoes

Instruction feeder for the multicycle processor: fetches 16-bit words from a synchronous program ROM and drives the processor's `DIN`/`Run` inputs, waiting on its `Done` output before issuing the next instruction. It supplies the second DIN word (immediate) for `mvi`, stops on a halt word or at the end of the address space, and flags a processor that never answers.

## Interface
- `LARG_END`, 5: ROM address width; program space is 2^LARG_END words.
- `TIMEOUT`, 15: maximum cycles spent in ESPERA without `Done` before raising `Erro`.
- `Clock`  in  1: single clock, all state updates on its rising edge.
- `Resetn`  in  1: reset, synchronous and active-low.
- `Iniciar`  in  1: one-cycle start pulse; begins execution at address 0.
- `MemEndereco`  out  LARG_END: ROM address.
- `MemDado`  in  16: ROM data, registered read, valid one cycle after `MemEndereco`.
- `Done`  in  1: processor completion, sampled every cycle.
- `DIN`  out  16: word presented to the processor.
- `Run`  out  1: processor start strobe, high exactly one cycle per instruction.
- `Ocupado`  out  1: high from the cycle after `Iniciar` until FIM/ERRO/OCIOSO.
- `Fim`  out  1: sticky, program ended normally.
- `Erro`  out  1: sticky, timeout or truncated `mvi`.
- `NumInstr`  out  8: instructions completed (`Done` received), saturates at 255.

## Operation
- States: OCIOSO, LE_MEM, ENVIA, IMEDIATO, ESPERA, FIM, ERRO. Pointer `pc` (LARG_END bits) drives `MemEndereco`.
- OCIOSO/FIM/ERRO + `Iniciar`: `pc`<=0, `NumInstr`<=0, `Fim`/`Erro`<=0, go LE_MEM. `Iniciar` in any other state is ignored.
- LE_MEM: ROM read of `pc` in flight; next ENVIA.
- ENVIA: if `MemDado`==16'hFFFF (halt), go FIM, no `Run`. Otherwise `DIN`=`MemDado`, `Run`=1, `pc`<=`pc`+1. If `MemDado[8:6]`==OPC_MVI, go IMEDIATO, else ESPERA. `Done` is ignored in ENVIA.
- IMEDIATO: `DIN`=`MemDado` (word at the incremented `pc`), `pc`<=`pc`+1. If `Done`=1 in this cycle, count the instruction and go LE_MEM. Otherwise go ESPERA.
- ESPERA: `DIN` holds its last value. On `Done`=1, `NumInstr`+1 and go LE_MEM, or FIM if `pc` wrapped to 0. If the watchdog reaches TIMEOUT, go ERRO.
- `mvi` fetched at address 2^LARG_END-1, where the immediate would wrap: go ERRO from ENVIA, no `Run`.
- FIM/ERRO: `Run`=0, `Ocupado`=0. Hold until `Iniciar` or reset.

## Timing
- Reset (`Resetn`=0 at an edge, in any state, including mid-instruction): state OCIOSO, `DIN`=0, `Run`=0, `MemEndereco`=0, `Ocupado`=0, `Fim`=0, `Erro`=0, `NumInstr`=0, watchdog=0.
- `Iniciar` at edge k: LE_MEM in cycle k+1, `Run` high in cycle k+2.
- Non-`mvi`: `Run` one cycle, then ESPERA. `Done` seen in cycle d gives LE_MEM at d+1 and the next `Run` at d+2.
- `mvi`: `Run` in cycle t, immediate on `DIN` in cycle t+1. This matches the processor's DIN capture at T1.
- Watchdog is cleared on entry to ESPERA and counts each ESPERA cycle. `Done` arriving in the same cycle the count reaches TIMEOUT wins: no error.
- `Run` and `Done` are never required high in the same cycle.
- `NumInstr` saturates at 8'hFF and never wraps.

## Structure
- Package `alimentador_pkg` holds:
  - state encodings (3 bits);
  - `OPC_MVI` = 3'b001;
  - `PALAVRA_FIM` = 16'hFFFF.
- Sub-module `contador_espera`, the watchdog: inputs `Clock`, `Clear`, `Habilita`; output `Estourou` when the count reaches TIMEOUT. `Clear` is synchronous.
- Everything else lives in one FSM plus datapath registers (`pc`, `DIN`, `NumInstr`).

## Test plan
- ROM {0: 16'h0008 (mv), 1: 16'hFFFF}, `Done` 2 cycles after `Run` -> one `Run` pulse with `DIN`=16'h0008, `NumInstr`=1, `Fim`=1, `Ocupado`=0.
- ROM {0: 16'h0040 (mvi R0), 1: 16'h00A5, 2: 16'hFFFF}, `Done` in the cycle after `Run` -> `DIN`=16'h0040 with `Run`, next cycle `DIN`=16'h00A5 with `Run`=0, `NumInstr`=1, `Fim`=1.
- Processor never asserts `Done` -> `Erro`=1 exactly TIMEOUT cycles after ESPERA entry, `Run` stays 0.
- `mvi` placed at address 31 (LARG_END=5) -> `Erro`=1, no `Run` for that word.
- `Resetn`=0 during ESPERA, then `Iniciar` -> all outputs zero after the reset edge, execution restarts at address 0 with `NumInstr` counting from 0.
- `Iniciar` pulsed while `Ocupado` -> ignored, and the `pc` sequence is unchanged.
